link_txn_sched: RTL and testbench
=================================

LINK_TXN_SCHED -- requirements
Module: link_txn_sched

Interface
REQ-001 SHALL have parameters EP_NUM, default 4, number of IN endpoints scheduled (2..8), and TIMER_W, default 16, handshake-timer width.
REQ-002 SHALL have ports: i_link_txn_sched_clk  in  1  sole clock, all logic rising-edge.
REQ-003 i_link_txn_sched_rst_n  in  1  asynchronous active-low reset.
REQ-004 i_link_txn_sched_tok_en  in  1  one-cycle token-received strobe; i_link_txn_sched_tok_pid  in  4  token PID; i_link_txn_sched_tok_ep  in  $clog2(EP_NUM)  endpoint.
REQ-005 i_link_txn_sched_ep_rdy  in  EP_NUM  per-endpoint IN data ready (level).
REQ-006 i_link_txn_sched_tx_lp_eop_en  in  1  transmit end-of-packet strobe.
REQ-007 i_link_txn_sched_rx_pid  in  4, i_link_txn_sched_rx_pid_en  in  1  received handshake PID plus strobe.
REQ-008 i_link_txn_sched_delay_threshold  in  6, i_link_txn_sched_time_threshold  in  TIMER_W  turnaround and handshake-timeout limits, cycles.
REQ-009 o_link_txn_sched_tx_data_on  out  1  one-cycle transmit start; o_link_txn_sched_tx_pid  out  4  PID to send; o_link_txn_sched_ep_sel  out  $clog2(EP_NUM)  granted endpoint.
REQ-010 o_link_txn_sched_ep_done  out  EP_NUM  one-hot one-cycle ACK-consumed pulse; o_link_txn_sched_time_out  out  1  one-cycle pulse; o_link_txn_sched_d_oe  out  1  1 = link drives PHY; o_link_txn_sched_busy  out  1  state != IDLE.

Function
REQ-011 FSM states SHALL be IDLE, TURN, SEND, WAIT_HS; all outputs registered.
REQ-012 In IDLE, tok_en with tok_pid IN (4'b1001) and tok_ep < EP_NUM SHALL latch ep_sel and enter TURN; other PIDs or out-of-range ep SHALL leave state IDLE.
REQ-013 tok_en with SETUP (4'b1101) SHALL set toggle[tok_ep]=1, state unchanged.
REQ-014 tok_en outside IDLE SHALL be ignored.
REQ-015 TURN: counter cleared on entry, +1 per cycle; when count == delay_threshold next state SEND; tx_data_on SHALL pulse in first SEND cycle, i.e. cycle N+2+delay_threshold for tok_en at cycle N.
REQ-016 tx_pid SHALL be latched on TURN entry: ep_rdy[ep] ? (toggle[ep] ? DATA1 4'b1011 : DATA0 4'b0011) : NAK 4'b1010.
REQ-017 d_oe SHALL be 1 from TURN entry through the SEND cycle receiving tx_lp_eop_en, else 0.
REQ-018 SEND + tx_lp_eop_en: DATA -> WAIT_HS; NAK/STALL -> IDLE; SEND waits indefinitely otherwise.
REQ-019 WAIT_HS: timer cleared on entry, +1 per cycle, saturates at all-ones.
REQ-020 WAIT_HS + rx_pid_en with ACK 4'b0010: toggle[ep] inverts, ep_done[ep] pulses next cycle, -> IDLE.
REQ-021 WAIT_HS + rx_pid_en with non-ACK PID: -> IDLE, toggle unchanged, no pulse.
REQ-022 timer == time_threshold without rx_pid_en: time_out pulses, toggle unchanged, -> IDLE; rx_pid_en in same cycle SHALL win over timeout.
REQ-023 time_threshold 0 SHALL time out in first WAIT_HS cycle; delay_threshold 0 SHALL give one TURN cycle.

Reset
REQ-024 Reset SHALL force IDLE, toggle[] = 0, counters 0, every output 0, including mid-transaction; no ep_done or time_out emitted for aborted transfer.

Configuration
REQ-025 Macro LINK_TXN_SCHED_STALL_EN defined: add input i_link_txn_sched_ep_stall  EP_NUM; stalled ep SHALL be answered with STALL 4'b1110, priority over data and NAK.
REQ-026 Macro undefined: port absent, STALL never issued.

Structure
REQ-027 Shared package link_pkg SHALL hold PID constants (IN, SETUP, DATA0, DATA1, ACK, NAK, STALL) and FSM state enum.
REQ-028 Turnaround and handshake counting SHALL share one sub-module link_txn_cnt (clear, enable, compare-to-limit, saturate).

Verification
REQ-029 IN ep1, ep_rdy=4'b0010, delay 3, toggle 0 -> tx_data_on at N+5, tx_pid 4'b0011, ep_sel 1, d_oe 1 until eop.
REQ-030 Then ACK 10 cycles after eop, time_threshold 100 -> ep_done 4'b0010, next IN ep1 sends DATA1.
REQ-031 IN ep2, ep_rdy=0 -> tx_pid 4'b1010, after eop IDLE, no WAIT_HS, no time_out.
REQ-032 DATA sent, no handshake, time_threshold 20 -> time_out 20 cycles after WAIT_HS entry, retry sends same DATA PID.
REQ-033 SETUP ep0 then IN ep0 ready -> DATA1; rst_n low during SEND -> all outputs 0 next edge, toggle 0.
REQ-034 With LINK_TXN_SCHED_STALL_EN, ep_stall=4'b0001, ep_rdy=4'b0001, IN ep0 -> tx_pid 4'b1110.

Source files
------------

// File: rtl/link_pkg.sv
// Shared definitions for the link transaction scheduler: token/handshake PID
// codes, the scheduler FSM state encoding and a small PID classifier.
package link_pkg;

    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TURN    = 2'd1,
        ST_SEND    = 2'd2,
        ST_WAIT_HS = 2'd3
    } link_state_e;

    // True for the two data PIDs; only data packets expect a handshake back.
    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/link_txn_cnt.sv
// Shared cycle counter: synchronous clear, count enable, saturation at
// all-ones and a combinational compare against a caller-supplied limit.
module link_txn_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_hit
);

    logic [CNT_W-1:0] r_count;

    // Count up while enabled, hold at all-ones, clear has priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_hit = (r_count == i_limit);

endmodule

// File: rtl/link_txn_sched.sv
// IN-transaction scheduler: on an IN token it waits a turnaround delay, sends
// DATA0/DATA1 (per-endpoint toggle) or NAK, then for data waits for the host
// handshake with a timeout. Optional macro LINK_TXN_SCHED_STALL_EN adds a
// per-endpoint stall input that makes the endpoint answer with STALL.
//
// Strobe protocol: tok_en, tx_lp_eop_en and rx_pid_en are single-cycle
// strobes with no back-pressure; a strobe arriving in a state that does not
// consume it is dropped. Output pulses (tx_data_on, ep_done, time_out) last
// exactly one cycle.
module link_txn_sched
    import link_pkg::*;
#(
    parameter int unsigned EP_NUM  = 4,
    parameter int unsigned TIMER_W = 16
) (
    input  logic                      i_link_txn_sched_clk,
    input  logic                      i_link_txn_sched_rst_n,
    input  logic                      i_link_txn_sched_tok_en,
    input  logic [3:0]                i_link_txn_sched_tok_pid,
    input  logic [$clog2(EP_NUM)-1:0] i_link_txn_sched_tok_ep,
    input  logic [EP_NUM-1:0]         i_link_txn_sched_ep_rdy,
`ifdef LINK_TXN_SCHED_STALL_EN
    input  logic [EP_NUM-1:0]         i_link_txn_sched_ep_stall,
`endif
    input  logic                      i_link_txn_sched_tx_lp_eop_en,
    input  logic [3:0]                i_link_txn_sched_rx_pid,
    input  logic                      i_link_txn_sched_rx_pid_en,
    input  logic [5:0]                i_link_txn_sched_delay_threshold,
    input  logic [TIMER_W-1:0]        i_link_txn_sched_time_threshold,
    output logic                      o_link_txn_sched_tx_data_on,
    output logic [3:0]                o_link_txn_sched_tx_pid,
    output logic [$clog2(EP_NUM)-1:0] o_link_txn_sched_ep_sel,
    output logic [EP_NUM-1:0]         o_link_txn_sched_ep_done,
    output logic                      o_link_txn_sched_time_out,
    output logic                      o_link_txn_sched_d_oe,
    output logic                      o_link_txn_sched_busy
);

    localparam int unsigned EP_W  = $clog2(EP_NUM);
    // One counter serves both the 6-bit turnaround and the handshake timer.
    localparam int unsigned CNT_W = (TIMER_W > 6) ? TIMER_W : 6;

    link_state_e       r_state;
    link_state_e       w_state_nxt;

    logic [EP_NUM-1:0] r_toggle;
    logic [EP_NUM-1:0] w_toggle_nxt;
    logic [3:0]        r_tx_pid;
    logic [3:0]        w_tx_pid_nxt;
    logic [EP_W-1:0]   r_ep_sel;
    logic [EP_W-1:0]   w_ep_sel_nxt;
    logic              r_tx_data_on;
    logic              w_tx_data_on_nxt;
    logic [EP_NUM-1:0] r_ep_done;
    logic [EP_NUM-1:0] w_ep_done_nxt;
    logic              r_time_out;
    logic              w_time_out_nxt;
    logic              r_d_oe;
    logic              w_d_oe_nxt;
    logic              r_busy;
    logic              w_busy_nxt;

    logic              w_tok_ep_ok;
    logic              w_tok_in;
    logic              w_tok_setup;
    logic              w_tok_stall;
    logic [3:0]        w_entry_pid;

    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic [CNT_W-1:0]  w_cnt_limit;
    logic              w_cnt_hit;

    assign w_tok_ep_ok = (32'(i_link_txn_sched_tok_ep) < EP_NUM);
    assign w_tok_in    = i_link_txn_sched_tok_en && w_tok_ep_ok &&
                         (i_link_txn_sched_tok_pid == PID_IN);
    assign w_tok_setup = i_link_txn_sched_tok_en && w_tok_ep_ok &&
                         (i_link_txn_sched_tok_pid == PID_SETUP);

`ifdef LINK_TXN_SCHED_STALL_EN
    assign w_tok_stall = i_link_txn_sched_ep_stall[i_link_txn_sched_tok_ep];
`else
    assign w_tok_stall = 1'b0;
`endif

    // Response PID chosen at token time: STALL beats data, data beats NAK.
    always_comb begin
        w_entry_pid = PID_NAK;
        if (w_tok_stall) begin
            w_entry_pid = PID_STALL;
        end else if (i_link_txn_sched_ep_rdy[i_link_txn_sched_tok_ep]) begin
            w_entry_pid = r_toggle[i_link_txn_sched_tok_ep] ? PID_DATA1 : PID_DATA0;
        end
    end

    // The counter restarts on every state change so TURN and WAIT_HS both
    // begin at zero; the limit follows whichever phase is counting.
    assign w_cnt_clr   = (w_state_nxt != r_state);
    assign w_cnt_en    = (r_state == ST_TURN) || (r_state == ST_WAIT_HS);
    assign w_cnt_limit = (r_state == ST_TURN) ? CNT_W'(i_link_txn_sched_delay_threshold)
                                              : CNT_W'(i_link_txn_sched_time_threshold);

    link_txn_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .i_clk   (i_link_txn_sched_clk),
        .i_rst_n (i_link_txn_sched_rst_n),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_limit (w_cnt_limit),
        .o_hit   (w_cnt_hit)
    );

    // State register.
    always_ff @(posedge i_link_txn_sched_clk or negedge i_link_txn_sched_rst_n) begin
        if (!i_link_txn_sched_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_tok_in) w_state_nxt = ST_TURN;
            end
            ST_TURN: begin
                if (w_cnt_hit) w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (i_link_txn_sched_tx_lp_eop_en) begin
                    w_state_nxt = is_data_pid(r_tx_pid) ? ST_WAIT_HS : ST_IDLE;
                end
            end
            ST_WAIT_HS: begin
                // A handshake in the timeout cycle still counts as received.
                if (i_link_txn_sched_rx_pid_en || w_cnt_hit) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output and data-toggle decode; every result lands in a register.
    always_comb begin
        w_toggle_nxt     = r_toggle;
        w_tx_pid_nxt     = r_tx_pid;
        w_ep_sel_nxt     = r_ep_sel;
        w_tx_data_on_nxt = 1'b0;
        w_ep_done_nxt    = '0;
        w_time_out_nxt   = 1'b0;
        w_d_oe_nxt       = (w_state_nxt == ST_TURN) || (w_state_nxt == ST_SEND);
        w_busy_nxt       = (w_state_nxt != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_tok_in) begin
                    w_ep_sel_nxt = i_link_txn_sched_tok_ep;
                    w_tx_pid_nxt = w_entry_pid;
                end else if (w_tok_setup) begin
                    w_toggle_nxt[i_link_txn_sched_tok_ep] = 1'b1;
                end
            end
            ST_TURN: begin
                w_tx_data_on_nxt = w_cnt_hit;
            end
            ST_WAIT_HS: begin
                if (i_link_txn_sched_rx_pid_en) begin
                    if (i_link_txn_sched_rx_pid == PID_ACK) begin
                        w_toggle_nxt[r_ep_sel]  = ~r_toggle[r_ep_sel];
                        w_ep_done_nxt[r_ep_sel] = 1'b1;
                    end
                end else if (w_cnt_hit) begin
                    w_time_out_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and toggle registers; reset drops any transfer in flight silently.
    always_ff @(posedge i_link_txn_sched_clk or negedge i_link_txn_sched_rst_n) begin
        if (!i_link_txn_sched_rst_n) begin
            r_toggle     <= '0;
            r_tx_pid     <= '0;
            r_ep_sel     <= '0;
            r_tx_data_on <= 1'b0;
            r_ep_done    <= '0;
            r_time_out   <= 1'b0;
            r_d_oe       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_toggle     <= w_toggle_nxt;
            r_tx_pid     <= w_tx_pid_nxt;
            r_ep_sel     <= w_ep_sel_nxt;
            r_tx_data_on <= w_tx_data_on_nxt;
            r_ep_done    <= w_ep_done_nxt;
            r_time_out   <= w_time_out_nxt;
            r_d_oe       <= w_d_oe_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign o_link_txn_sched_tx_data_on = r_tx_data_on;
    assign o_link_txn_sched_tx_pid     = r_tx_pid;
    assign o_link_txn_sched_ep_sel     = r_ep_sel;
    assign o_link_txn_sched_ep_done    = r_ep_done;
    assign o_link_txn_sched_time_out   = r_time_out;
    assign o_link_txn_sched_d_oe       = r_d_oe;
    assign o_link_txn_sched_busy       = r_busy;

endmodule

// File: tb/tb_link_txn_sched.sv
// Bench for link_txn_sched. Expected outputs are laid out per cycle in
// timeline arrays filled from transaction-level rules when each transaction
// is issued; a negedge process compares every output every cycle.
`timescale 1ns/1ps
module tb_link_txn_sched;

    localparam int EP_NUM  = 4;
    localparam int TIMER_W = 16;
    localparam int MAXC    = 1024;

    localparam logic [3:0] T_IN    = 4'b1001;
    localparam logic [3:0] T_SETUP = 4'b1101;
    localparam logic [3:0] T_DATA0 = 4'b0011;
    localparam logic [3:0] T_DATA1 = 4'b1011;
    localparam logic [3:0] T_ACK   = 4'b0010;
    localparam logic [3:0] T_NAK   = 4'b1010;
    localparam logic [3:0] T_STALL = 4'b1110;

    // ---------------- clock / reset / DUT ----------------
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               tok_en = 1'b0;
    logic [3:0]         tok_pid = '0;
    logic [1:0]         tok_ep = '0;
    logic [EP_NUM-1:0]  ep_rdy = '0;
    logic [EP_NUM-1:0]  ep_stall = '0;
    logic               eop = 1'b0;
    logic [3:0]         rx_pid = '0;
    logic               rx_en = 1'b0;
    logic [5:0]         delay_thr = '0;
    logic [TIMER_W-1:0] time_thr = '0;

    logic               o_on;
    logic [3:0]         o_pid;
    logic [1:0]         o_sel;
    logic [EP_NUM-1:0]  o_done;
    logic               o_to;
    logic               o_doe;
    logic               o_busy;

    always #5 clk = ~clk;

    link_txn_sched #(.EP_NUM(EP_NUM), .TIMER_W(TIMER_W)) dut (
        .i_link_txn_sched_clk             (clk),
        .i_link_txn_sched_rst_n           (rst_n),
        .i_link_txn_sched_tok_en          (tok_en),
        .i_link_txn_sched_tok_pid         (tok_pid),
        .i_link_txn_sched_tok_ep          (tok_ep),
        .i_link_txn_sched_ep_rdy          (ep_rdy),
`ifdef LINK_TXN_SCHED_STALL_EN
        .i_link_txn_sched_ep_stall        (ep_stall),
`endif
        .i_link_txn_sched_tx_lp_eop_en    (eop),
        .i_link_txn_sched_rx_pid          (rx_pid),
        .i_link_txn_sched_rx_pid_en       (rx_en),
        .i_link_txn_sched_delay_threshold (delay_thr),
        .i_link_txn_sched_time_threshold  (time_thr),
        .o_link_txn_sched_tx_data_on      (o_on),
        .o_link_txn_sched_tx_pid          (o_pid),
        .o_link_txn_sched_ep_sel          (o_sel),
        .o_link_txn_sched_ep_done         (o_done),
        .o_link_txn_sched_time_out        (o_to),
        .o_link_txn_sched_d_oe            (o_doe),
        .o_link_txn_sched_busy            (o_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model: expected timeline ----------------
    logic [3:0]        exp_pid  [MAXC];
    logic [1:0]        exp_sel  [MAXC];
    logic              exp_on   [MAXC];
    logic              exp_doe  [MAXC];
    logic              exp_busy [MAXC];
    logic              exp_to   [MAXC];
    logic [EP_NUM-1:0] exp_done [MAXC];
    logic [EP_NUM-1:0] m_toggle = '0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int         last_on_cyc = -1;
    logic [3:0] on_pid = '0;
    logic [1:0] on_sel = '0;
    int         last_to_cyc = -1;
    int         to_cnt = 0;
    int         last_done_cyc = -1;
    logic [EP_NUM-1:0] last_done = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endfunction

    function automatic void zero_from(int r);
        for (int i = r; i < MAXC; i++) begin
            exp_pid[i] = '0; exp_sel[i] = '0; exp_on[i] = 1'b0; exp_doe[i] = 1'b0;
            exp_busy[i] = 1'b0; exp_to[i] = 1'b0; exp_done[i] = '0;
        end
    endfunction

    function automatic void hold_pid_sel(int from, logic [3:0] p, logic [1:0] s);
        for (int i = from; i < MAXC; i++) begin
            exp_pid[i] = p;
            exp_sel[i] = s;
        end
    endfunction

    function automatic void set_active(int a, int b, logic busy, logic doe);
        for (int i = a; i <= b && i < MAXC; i++) begin
            exp_busy[i] = busy;
            exp_doe[i]  = doe;
        end
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            if (cyc >= MAXC) begin
                chk("cycle_budget", cyc, MAXC - 1);
                chk_en = 1'b0;
            end else begin
                chk("tx_data_on", o_on, exp_on[cyc]);
                chk("tx_pid", o_pid, exp_pid[cyc]);
                chk("ep_sel", o_sel, exp_sel[cyc]);
                chk("ep_done", o_done, exp_done[cyc]);
                chk("time_out", o_to, exp_to[cyc]);
                chk("d_oe", o_doe, exp_doe[cyc]);
                chk("busy", o_busy, exp_busy[cyc]);
            end
            if (o_on === 1'b1) begin last_on_cyc = cyc; on_pid = o_pid; on_sel = o_sel; end
            if (o_to === 1'b1) begin last_to_cyc = cyc; to_cnt++; end
            if (|o_done) begin last_done_cyc = cyc; last_done = o_done; end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // IN token at the current cycle; SEND then lasts until an eop arrives.
    task automatic tok_in(input int ep, input int d, input bit stray, output int s);
        int n;
        logic [3:0] p;
        n = cyc;
        if (ep_stall[ep]) p = T_STALL;
        else if (ep_rdy[ep]) p = m_toggle[ep] ? T_DATA1 : T_DATA0;
        else p = T_NAK;
        s = n + 2 + d;
        hold_pid_sel(n + 1, p, 2'(ep));
        set_active(n + 1, MAXC - 1, 1'b1, 1'b1);
        exp_on[s] = 1'b1;
        delay_thr = 6'(d);
        tok_en = 1'b1; tok_pid = T_IN; tok_ep = 2'(ep);
        tick();
        tok_en = 1'b0;
        if (stray) begin
            // tokens while busy must change nothing, not even the toggle
            tok_en = 1'b1; tok_pid = T_SETUP; tok_ep = 2'(ep);
            tick();
            tok_pid = T_IN; tok_ep = 2'((ep + 1) % EP_NUM);
            tick();
            tok_en = 1'b0;
        end
    endtask

    task automatic in_txn(input int ep, input int d, input int extra, input bit stray,
                          output int e);
        int s;
        tok_in(ep, d, stray, s);
        e = s + extra;
        set_active(e + 1, MAXC - 1, 1'b0, 1'b0);
        wait_until(e);
        eop = 1'b1;
        tick();
        eop = 1'b0;
    endtask

    // Called in the first WAIT_HS cycle; j < 0 means the host never answers.
    task automatic handshake(input int j, input logic [3:0] pid, input int ep);
        int w, thr;
        w = cyc;
        thr = int'(time_thr);
        if (j >= 0 && j <= thr) begin
            set_active(w, w + j, 1'b1, 1'b0);
            if (pid == T_ACK) begin
                exp_done[w + j + 1][ep] = 1'b1;
                m_toggle[ep] = ~m_toggle[ep];
            end
            wait_until(w + j);
            rx_en = 1'b1; rx_pid = pid;
            tick();
            rx_en = 1'b0;
        end else begin
            set_active(w, w + thr, 1'b1, 1'b0);
            exp_to[w + thr + 1] = 1'b1;
            wait_until(w + thr + 1);
        end
        tick();
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        zero_from(cyc);
        m_toggle = '0;
        tok_en = 1'b0; eop = 1'b0; rx_en = 1'b0;
        #1;
        chk("rst_async_d_oe", o_doe, 0);
        chk("rst_async_busy", o_busy, 0);
        chk("rst_async_tx_pid", o_pid, 0);
        chk("rst_async_ep_sel", o_sel, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int e, s, n, w, t0;
        zero_from(0);
        time_thr = TIMER_W'(100);
        chk_en = 1'b1;
        repeat (3) tick();
        chk("reset_busy", o_busy, 0);
        chk("reset_tx_pid", o_pid, 0);
        rst_n = 1'b1;
        tick();

        // IN ep1, ready, delay 3, toggle 0 -> DATA0 five cycles after token
        ep_rdy = 4'b0010;
        n = cyc;
        in_txn(1, 3, 2, 1'b1, e);
        chk("in_ep1_on_latency", last_on_cyc - n, 5);
        chk("in_ep1_pid", on_pid, 4'b0011);
        chk("in_ep1_sel", on_sel, 1);

        // ACK 10 cycles after eop -> ep_done on ep1, next IN sends DATA1
        handshake(9, T_ACK, 1);
        chk("ack_done_vec", last_done, 4'b0010);
        chk("ack_done_cycle", last_done_cyc - e, 11);
        in_txn(1, 3, 0, 1'b0, e);
        chk("in_ep1_after_ack_pid", on_pid, 4'b1011);
        handshake(2, T_NAK, 1);

        // IN ep2 not ready -> NAK, straight back to IDLE, no timeout
        time_thr = TIMER_W'(20);
        t0 = to_cnt;
        in_txn(2, 2, 1, 1'b0, e);
        chk("nak_pid", on_pid, 4'b1010);
        repeat (25) tick();
        chk("nak_no_timeout", to_cnt - t0, 0);

        // data, no handshake, threshold 20 -> timeout, retry repeats DATA1
        in_txn(1, 1, 3, 1'b0, e);
        chk("to_first_pid", on_pid, 4'b1011);
        w = cyc;
        handshake(-1, 4'b0000, 1);
        chk("to_cycle_thr20", last_to_cyc - w, 21);
        n = cyc;
        in_txn(1, 0, 0, 1'b0, e);
        chk("delay0_on_latency", last_on_cyc - n, 2);
        chk("retry_pid", on_pid, 4'b1011);
        time_thr = '0;
        w = cyc;
        handshake(-1, 4'b0000, 1);
        chk("to_cycle_thr0", last_to_cyc - w, 1);

        // handshake in the timeout cycle wins
        time_thr = TIMER_W'(5);
        t0 = to_cnt;
        in_txn(1, 2, 0, 1'b0, e);
        handshake(5, T_ACK, 1);
        chk("rx_beats_timeout_to", to_cnt - t0, 0);
        chk("rx_beats_timeout_done", last_done, 4'b0010);

        // non-IN token in IDLE does nothing
        tok_en = 1'b1; tok_pid = 4'b0001; tok_ep = 2'd1;
        tick();
        tok_en = 1'b0;
        tick();
        chk("out_tok_idle_busy", o_busy, 0);

        // SETUP ep0 then IN ep0 -> DATA1; reset in SEND clears everything
        ep_rdy = 4'b0001;
        tok_en = 1'b1; tok_pid = T_SETUP; tok_ep = 2'd0;
        m_toggle[0] = 1'b1;
        tick();
        tok_en = 1'b0;
        tick();
        tok_in(0, 2, 1'b0, s);
        wait_until(s + 1);
        chk("setup_in_pid", on_pid, 4'b1011);
        mid_reset();
        n = cyc;
        in_txn(0, 1, 0, 1'b0, e);
        chk("after_reset_pid", on_pid, 4'b0011);
        chk("after_reset_on_latency", last_on_cyc - n, 3);
        time_thr = TIMER_W'(100);
        handshake(0, T_ACK, 0);
        chk("after_reset_done", last_done, 4'b0001);

`ifdef LINK_TXN_SCHED_STALL_EN
        // stalled endpoint answers STALL even when ready, no handshake phase
        ep_stall = 4'b0001;
        ep_rdy = 4'b0001;
        in_txn(0, 1, 1, 1'b0, e);
        chk("stall_pid", on_pid, 4'b1110);
        ep_stall = '0;
`endif

        repeat (5) tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit in case a scenario ever stalls.
    initial begin
        #(MAXC * 10 + 100);
        errors++;
        $display("FAIL watchdog actual=%0d required<%0d cycles", cyc, MAXC);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
